// File: rtl/felis_sb_pkg.sv
// -----------------------------------------------------------------------------
// felis_sb_pkg
// Shared types and helpers for the issue-stage register scoreboard.
//   reg_idx_t   : 5-bit architectural register index
//   NREG        : registers per file (general / float)
//   sb_state_t  : scoreboard control state (normal issue / draining)
//   cnt_max()   : largest value a CNT_W-bit pending-write counter can hold
// -----------------------------------------------------------------------------
package felis_sb_pkg;

    localparam int NREG = 32;

    typedef logic [4:0] reg_idx_t;

    typedef enum logic {
        SB_RUN   = 1'b0,
        SB_DRAIN = 1'b1
    } sb_state_t;

    function automatic int cnt_max(input int cnt_w);
        return (1 << cnt_w) - 1;
    endfunction

endpackage

// File: rtl/sb_counter_bank.sv
// -----------------------------------------------------------------------------
// sb_counter_bank
// One register file's worth of pending-write counters (NREG entries).
// Ports:
//   clk, rst            : clock, synchronous active-high reset (clears counts)
//   inc_valid/inc_num   : an issuing instruction will write register inc_num
//   dec_valid/dec_num   : a writeback to register dec_num completes
//   rd_num[3]           : source registers to look up
//   rd_pending[3]       : effective count of rd_num[k] is nonzero
//   dst_num/dst_full    : effective count of dst_num is at counter maximum
//   busy                : per-register registered count != 0
//   all_zero            : every registered count is 0
//   spurious_dec        : writeback this cycle hits a counter already at 0
// The "effective" count subtracts a same-cycle writeback so a dependent
// instruction can issue in the very cycle its producer writes back.
// With ZERO_HARDWIRED=1, register 0 is never counted and never reports
// a spurious writeback.
// -----------------------------------------------------------------------------
module sb_counter_bank
    import felis_sb_pkg::*;
#(
    parameter int CNT_W          = 2,
    parameter bit ZERO_HARDWIRED = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inc_valid,
    input  reg_idx_t        inc_num,
    input  logic            dec_valid,
    input  reg_idx_t        dec_num,
    input  reg_idx_t        rd_num [3],
    output logic [2:0]      rd_pending,
    input  reg_idx_t        dst_num,
    output logic            dst_full,
    output logic [NREG-1:0] busy,
    output logic            all_zero,
    output logic            spurious_dec
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

    logic [CNT_W-1:0] cnt_q [NREG];
    logic [CNT_W-1:0] cnt_d [NREG];
    logic [CNT_W-1:0] eff   [NREG];
    logic [NREG-1:0]  dec_hit;
    logic [NREG-1:0]  inc_hit;

    always_comb begin
        dec_hit = '0;
        inc_hit = '0;
        busy    = '0;
        for (int r = 0; r < NREG; r++) begin
            if (!(ZERO_HARDWIRED && r == 0)) begin
                // A writeback only counts down a register that has something pending
                dec_hit[r] = dec_valid && (dec_num == reg_idx_t'(r)) && (cnt_q[r] != '0);
                inc_hit[r] = inc_valid && (inc_num == reg_idx_t'(r));
            end
            eff[r]   = cnt_q[r] - CNT_W'(dec_hit[r]);
            cnt_d[r] = eff[r] + CNT_W'(inc_hit[r]);
            busy[r]  = (cnt_q[r] != '0);
        end
    end

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            rd_pending[k] = (eff[rd_num[k]] != '0);
        end
        dst_full     = (eff[dst_num] == CNT_MAX);
        all_zero     = (busy == '0);
        spurious_dec = dec_valid
                       && !(ZERO_HARDWIRED && dec_num == '0)
                       && (cnt_q[dec_num] == '0);
    end

    always_ff @(posedge clk) begin
        for (int r = 0; r < NREG; r++) begin
            if (rst) begin
                cnt_q[r] <= '0;
            end else begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

endmodule

// File: rtl/reg_scoreboard.sv
// -----------------------------------------------------------------------------
// reg_scoreboard
// Issue-stage hazard tracker sitting right after the instruction decoder.
// Tracks outstanding writes per general and float register and holds off
// issue on read-after-write hazards or when a destination counter is full.
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   issue_valid / issue_ready    : decoded instruction offered / may issue
//   src_reg_num[3], src_valid,
//   src_float                    : source registers, read flags, file selects
//   dst_reg_num, dst_general,
//   dst_float                    : destination register and its file
//   wb_gen_valid/num,
//   wb_flt_valid/num             : writeback completions per file
//   drain_req / drain_done       : flush request (level) / completion pulse
//   gen_busy, flt_busy           : registered per-register pending flags
//   err_spurious_wb              : sticky, writeback with nothing pending
// -----------------------------------------------------------------------------
module reg_scoreboard #(
    parameter int CNT_W = 2,
    parameter int NREG  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    output logic                  issue_ready,
    input  felis_sb_pkg::reg_idx_t src_reg_num [3],
    input  logic [2:0]            src_valid,
    input  logic [2:0]            src_float,
    input  felis_sb_pkg::reg_idx_t dst_reg_num,
    input  logic                  dst_general,
    input  logic                  dst_float,
    input  logic                  wb_gen_valid,
    input  felis_sb_pkg::reg_idx_t wb_gen_num,
    input  logic                  wb_flt_valid,
    input  felis_sb_pkg::reg_idx_t wb_flt_num,
    input  logic                  drain_req,
    output logic                  drain_done,
    output logic [NREG-1:0]       gen_busy,
    output logic [NREG-1:0]       flt_busy,
    output logic                  err_spurious_wb
);

    import felis_sb_pkg::*;

    sb_state_t  state_q, state_d;
    logic       drain_done_q, drain_done_d;
    logic       err_q, err_d;

    logic [2:0] gen_rd_pending, flt_rd_pending;
    logic       gen_dst_full, flt_dst_full;
    logic       gen_all_zero, flt_all_zero;
    logic       gen_spurious, flt_spurious;
    logic       raw_hazard, waw_full, fire;

    sb_counter_bank #(.CNT_W(CNT_W), .ZERO_HARDWIRED(1'b1)) u_gen_bank (
        .clk          (clk),
        .rst          (rst),
        .inc_valid    (fire && dst_general),
        .inc_num      (dst_reg_num),
        .dec_valid    (wb_gen_valid),
        .dec_num      (wb_gen_num),
        .rd_num       (src_reg_num),
        .rd_pending   (gen_rd_pending),
        .dst_num      (dst_reg_num),
        .dst_full     (gen_dst_full),
        .busy         (gen_busy),
        .all_zero     (gen_all_zero),
        .spurious_dec (gen_spurious)
    );

    sb_counter_bank #(.CNT_W(CNT_W), .ZERO_HARDWIRED(1'b0)) u_flt_bank (
        .clk          (clk),
        .rst          (rst),
        .inc_valid    (fire && dst_float),
        .inc_num      (dst_reg_num),
        .dec_valid    (wb_flt_valid),
        .dec_num      (wb_flt_num),
        .rd_num       (src_reg_num),
        .rd_pending   (flt_rd_pending),
        .dst_num      (dst_reg_num),
        .dst_full     (flt_dst_full),
        .busy         (flt_busy),
        .all_zero     (flt_all_zero),
        .spurious_dec (flt_spurious)
    );

    // Both banks look up every source; the file select picks whose answer counts
    always_comb begin
        raw_hazard  = |(src_valid & ~src_float & gen_rd_pending)
                    | |(src_valid &  src_float & flt_rd_pending);
        waw_full    = (dst_general && gen_dst_full) || (dst_float && flt_dst_full);
        issue_ready = (state_q == SB_RUN) && !rst && !raw_hazard && !waw_full;
        fire        = issue_valid && issue_ready;
    end

    always_comb begin
        state_d      = state_q;
        drain_done_d = 1'b0;
        err_d        = err_q || gen_spurious || flt_spurious;
        case (state_q)
            SB_RUN: begin
                if (drain_req) begin
                    state_d = SB_DRAIN;
                end
            end
            SB_DRAIN: begin
                // all_zero is built from registered counts, so the pulse lands
                // one cycle after the last writeback took effect
                if (gen_all_zero && flt_all_zero) begin
                    state_d      = SB_RUN;
                    drain_done_d = 1'b1;
                end
            end
            default: state_d = SB_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= SB_RUN;
            drain_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            drain_done_q <= drain_done_d;
            err_q        <= err_d;
        end
    end

    assign drain_done      = drain_done_q;
    assign err_spurious_wb = err_q;

endmodule
